// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter: shares the single-port frame memory between the capture
// writer and the display reader. Arbitration is round-robin with bounded bursts.
// It also runs a full-frame clear sequence on command.
module frame_mem_arbiter #(
    parameter int          FRAME_SIZE = 307200,
    parameter int          MAX_BURST  = 16,
    parameter logic [7:0]  CLEAR_VAL  = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_start,
    output logic        clear_busy,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    input  logic        rd_req,
    input  logic [18:0] rd_addr,
    output logic        rd_ack,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_data_in,
    output logic        mem_we,
    input  logic [7:0]  mem_data_out
);

    localparam int          BW          = $clog2(MAX_BURST + 1);
    localparam logic [18:0] FRAME_LIMIT = 19'(FRAME_SIZE);
    localparam logic [18:0] LAST_ADDR   = 19'(FRAME_SIZE - 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {IDLE, CLEAR} state_t;
    typedef enum logic {OWN_WR, OWN_RD} owner_t;

    state_t        state, state_next;
    owner_t        owner;
    logic [BW-1:0] burst_cnt;
    logic [18:0]   clr_addr;
    logic [18:0]   last_addr;
    logic          rd_pend;
    logic          rd_oor;
    logic          grant_wr, grant_rd;

    // Next-state and per-cycle grant decision; the owner keeps the port until its burst is spent
    always_comb begin
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;
        state_next = state;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (wr_req && rd_req) begin
                        if (owner == OWN_WR) begin
                            if (burst_cnt == BURST_MAX) grant_rd = 1'b1;
                            else                        grant_wr = 1'b1;
                        end else begin
                            if (burst_cnt == BURST_MAX) grant_wr = 1'b1;
                            else                        grant_rd = 1'b1;
                        end
                    end else begin
                        grant_wr = wr_req;
                        grant_rd = rd_req;
                    end
                    if (clear_start) state_next = CLEAR;
                end
                CLEAR: begin
                    if (clr_addr == LAST_ADDR) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Memory port mux: granted source, else the clear writer, else hold the last address
    always_comb begin
        mem_addr    = last_addr;
        mem_data_in = 8'h00;
        mem_we      = 1'b0;
        if (grant_wr) begin
            mem_addr    = wr_addr;
            mem_data_in = wr_data;
            mem_we      = (wr_addr < FRAME_LIMIT);
        end else if (grant_rd) begin
            mem_addr = rd_addr;
        end else if (state == CLEAR && !reset) begin
            mem_addr    = clr_addr;
            mem_data_in = CLEAR_VAL;
            mem_we      = 1'b1;
        end
    end

    assign wr_ack   = grant_wr;
    assign rd_ack   = grant_rd;
    assign rd_valid = rd_pend & ~reset;
    assign rd_data  = (rd_valid && !rd_oor) ? mem_data_out : 8'h00;

    // FSM state register, clear address walk and the registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            clr_addr   <= '0;
            clear_busy <= 1'b0;
        end else begin
            state      <= state_next;
            clear_busy <= (state_next == CLEAR);
            if (state == CLEAR) begin
                clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 19'd1;
            end
        end
    end

    // Burst bookkeeping: a new owner starts at one, the same owner counts up to saturation
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= OWN_RD;
            burst_cnt <= '0;
        end else if (grant_wr || grant_rd) begin
            if ((grant_wr && owner == OWN_WR) || (grant_rd && owner == OWN_RD)) begin
                if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else begin
                owner     <= grant_wr ? OWN_WR : OWN_RD;
                burst_cnt <= BW'(1);
            end
        end
    end

    // Read return tracking and the held address for idle cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend   <= 1'b0;
            rd_oor    <= 1'b0;
            last_addr <= '0;
        end else begin
            rd_pend   <= grant_rd;
            rd_oor    <= (rd_addr >= FRAME_LIMIT);
            last_addr <= mem_addr;
        end
    end

endmodule
